// File: rtl/stream_demux_1x2.sv
// stream_demux_1x2: routes one input stream to two independent lane FIFOs (x, y).
// in_sel picks the lane for each accepted word; each lane has its own DEPTH-entry
// FIFO with occupancy count. Outputs are registered state only, so there is no
// combinational path from the input side to either lane's outputs.
module stream_demux_1x2 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic                       in_sel,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       in_ready,
  output logic                       x_valid,
  input  logic                       x_ready,
  output logic [DATA_W-1:0]          x_data,
  output logic [$clog2(DEPTH):0]     x_count,
  output logic                       y_valid,
  input  logic                       y_ready,
  output logic [DATA_W-1:0]          y_data,
  output logic [$clog2(DEPTH):0]     y_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  // lane index 0 is x, lane index 1 is y
  logic [1:0]             lane_sel;
  logic [1:0]             lane_push;
  logic [1:0]             lane_pop;
  logic [1:0]             lane_full;
  logic [1:0]             lane_valid;
  logic [1:0]             lane_ready;
  logic [1:0][DATA_W-1:0] lane_data;
  logic [1:0][CW-1:0]     lane_count;

  assign lane_sel   = {in_sel, ~in_sel};
  assign lane_ready = {y_ready, x_ready};

  // Only the selected lane's fullness matters; a pop in the same cycle does not
  // free a slot for the incoming word (no full-FIFO pass-through).
  assign in_ready  = |(lane_sel & ~lane_full);
  assign lane_push = lane_sel & {2{in_valid & in_ready}};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_lane
      logic [DATA_W-1:0] mem [DEPTH];
      logic [AW-1:0]     wr_ptr;
      logic [AW-1:0]     rd_ptr;
      logic [CW-1:0]     count;

      assign lane_valid[g] = (count != '0);
      assign lane_full[g]  = (count == CW'(DEPTH));
      assign lane_pop[g]   = lane_valid[g] & lane_ready[g];
      assign lane_count[g] = count;
      // head word is masked while empty so stale/unreset storage never leaks out
      assign lane_data[g]  = lane_valid[g] ? mem[rd_ptr] : '0;

      // Storage write; the array itself is not reset, visibility is via count.
      always_ff @(posedge clk) begin
        if (lane_push[g] && !rst) begin
          mem[wr_ptr] <= in_data;
        end
      end

      // Pointers wrap naturally at DEPTH (power of two); count nets push vs pop.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end else begin
          if (lane_push[g]) wr_ptr <= wr_ptr + AW'(1);
          if (lane_pop[g])  rd_ptr <= rd_ptr + AW'(1);
          case ({lane_push[g], lane_pop[g]})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
          endcase
        end
      end
    end
  endgenerate

  assign x_valid = lane_valid[0];
  assign x_data  = lane_data[0];
  assign x_count = lane_count[0];
  assign y_valid = lane_valid[1];
  assign y_data  = lane_data[1];
  assign y_count = lane_count[1];

endmodule

// File: tb/tb_stream_demux_1x2.sv
// Bench for stream_demux_1x2: queue-based lane model checked every negedge,
// directed scenarios with literal expectations, then randomized traffic.
module tb_stream_demux_1x2;
  localparam int DW = 8;
  localparam int D  = 4;
  localparam int CW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_sel, in_ready;
  logic [DW-1:0] in_data;
  logic          x_valid, x_ready, y_valid, y_ready;
  logic [DW-1:0] x_data, y_data;
  logic [CW-1:0] x_count, y_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] qx[$];
  logic [DW-1:0] qy[$];
  logic [DW-1:0] got[$];
  bit            m_rdy, m_pop_x, m_pop_y;

  stream_demux_1x2 #(.DATA_W(DW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sel(in_sel), .in_data(in_data), .in_ready(in_ready),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_count(x_count),
    .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data), .y_count(y_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: two plain queues; a full lane refuses even if it pops this edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      qx.delete();
      qy.delete();
    end else begin
      m_rdy   = in_sel ? (qy.size() < D) : (qx.size() < D);
      m_pop_x = (qx.size() > 0) && x_ready;
      m_pop_y = (qy.size() > 0) && y_ready;
      if (m_pop_x) void'(qx.pop_front());
      if (m_pop_y) void'(qy.pop_front());
      if (in_valid && m_rdy) begin
        if (in_sel) qy.push_back(in_data);
        else        qx.push_back(in_data);
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("x_valid",  x_valid, qx.size() > 0);
    chk("x_count",  x_count, qx.size());
    chk("x_data",   x_data,  (qx.size() > 0) ? qx[0] : '0);
    chk("y_valid",  y_valid, qy.size() > 0);
    chk("y_count",  y_count, qy.size());
    chk("y_data",   y_data,  (qy.size() > 0) ? qy[0] : '0);
    chk("in_ready", in_ready, in_sel ? (qy.size() < D) : (qx.size() < D));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sel, input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int idx, budget;
    logic [DW-1:0] exp_y035 [6];
    exp_y035 = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 8'h07};

    rst = 1'b0;
    in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    x_ready = 1'b0; y_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_x_valid", x_valid, 0);
    chk("rst_y_valid", y_valid, 0);
    chk("rst_x_count", x_count, 0);
    chk("rst_y_data", y_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // route: first edge after reset accepts the word
    push(1'b0, 8'hA5);
    chk("route_x_valid", x_valid, 1);
    chk("route_x_data", x_data, 8'hA5);
    chk("route_x_count", x_count, 1);
    chk("route_y_valid", y_valid, 0);
    chk("route_y_data", y_data, 0);
    x_ready = 1'b1; tick(); x_ready = 1'b0;
    chk("route_x_drained", x_count, 0);
    chk("route_x_data_zero", x_data, 0);

    // fill y, fifth word refused
    for (int i = 1; i <= 4; i++) push(1'b1, DW'(i));
    chk("fill_y_count", y_count, 4);
    in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h05;
    #1 chk("fill_ready_y", in_ready, 0);
    in_sel = 1'b0;
    #1 chk("fill_ready_x", in_ready, 1);
    in_sel = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("fill_y_count_hold", y_count, 4);
    chk("fill_y_head", y_data, 8'h01);
    chk("fill_x_count", x_count, 0);

    // drain and wrap
    y_ready = 1'b1;
    in_sel = 1'b1;
    in_valid = 1'b1; in_data = 8'h06;
    #1 chk("full_no_passthru", in_ready, 0);
    got.delete();
    idx = 0;
    budget = 0;
    while (got.size() < 6 && budget < 20) begin
      bit acc;
      in_valid = (idx < 2);
      in_data  = (idx == 0) ? 8'h06 : 8'h07;
      #2;
      if (y_valid) got.push_back(y_data);
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
      budget++;
    end
    in_valid = 1'b0;
    chk("wrap_len", got.size(), 6);
    for (int i = 0; i < 6 && i < got.size(); i++) chk("wrap_seq", got[i], exp_y035[i]);
    tick();
    chk("wrap_y_count", y_count, 0);
    y_ready = 1'b0;

    // simultaneous push and pop on x
    push(1'b0, 8'h21);
    push(1'b0, 8'h22);
    chk("simul_pre_count", x_count, 2);
    in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h23; x_ready = 1'b1;
    tick();
    in_valid = 1'b0; x_ready = 1'b0;
    chk("simul_count", x_count, 2);
    chk("simul_head", x_data, 8'h22);
    x_ready = 1'b1; tick(); tick(); x_ready = 1'b0;
    chk("simul_drained", x_count, 0);

    // independence: x full, y streams freely
    for (int i = 0; i < 4; i++) push(1'b0, 8'h30 + DW'(i));
    chk("indep_x_full", x_count, 4);
    y_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 7; i++) begin
      in_valid = (i < 4); in_sel = 1'b1; in_data = 8'h10 + DW'(i);
      #2;
      if (i < 4) chk("indep_y_ready", in_ready, 1);
      if (y_valid) got.push_back(y_data);
      tick();
    end
    in_valid = 1'b0;
    chk("indep_len", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("indep_seq", got[i], 8'h10 + i);
    chk("indep_x_count", x_count, 4);
    chk("indep_x_head", x_data, 8'h30);
    y_ready = 1'b0;
    x_ready = 1'b1; repeat (4) tick(); x_ready = 1'b0;

    // asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) push(1'b0, 8'h40 + DW'(i));
    for (int i = 0; i < 2; i++) push(1'b1, 8'h50 + DW'(i));
    chk("rstmid_x_count", x_count, 3);
    chk("rstmid_y_count", y_count, 2);
    in_valid = 1'b1; in_sel = 1'b1; in_data = 8'h77;
    #2 rst = 1'b1;
    #1;
    chk("rstmid_x_count0", x_count, 0);
    chk("rstmid_y_count0", y_count, 0);
    chk("rstmid_x_valid", x_valid, 0);
    chk("rstmid_y_valid", y_valid, 0);
    chk("rstmid_x_data", x_data, 0);
    chk("rstmid_y_data", y_data, 0);
    chk("rstmid_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #2 rst = 1'b0;
    tick();
    chk("rstmid_no_store", y_count, 0);

    // randomized traffic with shifting biases and between-edge glitches
    for (int blk = 0; blk < 10; blk++) begin
      int pv, pxr, pyr, ps;
      pv  = $urandom_range(30, 100);
      pxr = $urandom_range(0, 100);
      pyr = $urandom_range(0, 100);
      ps  = $urandom_range(10, 90);
      for (int c = 0; c < 200; c++) begin
        in_sel  = $urandom_range(0, 1);
        in_data = DW'($urandom);
        #1;
        in_valid = ($urandom_range(0, 99) < pv);
        in_sel   = ($urandom_range(0, 99) < ps);
        in_data  = DW'($urandom);
        x_ready  = ($urandom_range(0, 99) < pxr);
        y_ready  = ($urandom_range(0, 99) < pyr);
        tick();
      end
    end
    in_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
